multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OPC_W, default 6, opcode field width.
REQ-002 SHALL have parameter FUNCT_W, default 6, funct field width.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port opcode  in  OPC_W  instruction[31:26] taken from the instruction register.
REQ-006 SHALL have port funct  in  FUNCT_W  instruction[5:0] taken from the instruction register.
REQ-007 SHALL have port mem_ready  in  1  shared memory has completed the current read or write.
REQ-008 SHALL have port pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write  out  1 each  datapath enables.
REQ-009 SHALL have port alu_src_a  out  1  0=PC, 1=A register.
REQ-010 SHALL have port alu_src_b  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2.
REQ-011 SHALL have port alu_op  out  2  00=add, 01=sub, 10=decode by funct.
REQ-012 SHALL have port pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A register (jr).
REQ-013 SHALL have port reg_dst  out  2  00=rt, 01=rd, 10=r31.
REQ-014 SHALL have port mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC.
REQ-015 SHALL have port instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-016 SHALL have port illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-017 SHALL have port state_dbg  out  4  current state encoding.

Function
REQ-018 SHALL implement a Moore FSM; every output SHALL be a function of the current state only, except the mem_ready gating defined in REQ-020 and REQ-024.
REQ-019 SHALL have the states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP, JAL, JR.
REQ-020 FETCH SHALL assert mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_source=00; it SHALL assert ir_write and pc_write only in a cycle with mem_ready=1, and SHALL hold in FETCH while mem_ready=0.
REQ-021 DECODE SHALL assert alu_src_a=0, alu_src_b=11 and alu_op=00 (branch target into ALUOut), then branch on opcode:
- 000000 with funct 001000 -> JR; other 000000 -> EXEC_R
- 100011/101011 -> MEM_ADR
- 000100 -> BRANCH
- 001000 -> ADDI_EX
- 000010 -> JUMP
- 000011 -> JAL
- any other opcode -> FETCH, pulsing illegal_op.
REQ-022 MEM_ADR SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-023 MEM_RD SHALL assert mem_read and i_or_d, holding while mem_ready=0, and SHALL go to MEM_WB on mem_ready.
REQ-024 MEM_WR SHALL assert mem_write and i_or_d, holding while mem_ready=0; it SHALL go to FETCH on mem_ready, asserting instr_done in that cycle.
REQ-025 MEM_WB SHALL assert reg_write with reg_dst=00 and mem_to_reg=01.
REQ-026 EXEC_R SHALL assert alu_src_a=1, alu_src_b=00 and alu_op=10.
REQ-027 R_WB SHALL assert reg_write with reg_dst=01 and mem_to_reg=00.
REQ-028 ADDI_EX SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=00.
REQ-029 ADDI_WB SHALL assert reg_write with reg_dst=00 and mem_to_reg=00.
REQ-030 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond and pc_source=01.
REQ-031 JUMP SHALL assert pc_write with pc_source=10.
REQ-032 JAL SHALL assert pc_write with pc_source=10 and reg_write with reg_dst=10 and mem_to_reg=10; the PC already holds PC+4, so the link value is correct.
REQ-033 JR SHALL assert pc_write with pc_source=11.
REQ-034 MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, JAL and JR SHALL each return to FETCH and assert instr_done.
REQ-035 Any state encoding not listed in REQ-019 SHALL transition to FETCH on the next cycle.
REQ-036 mem_read and mem_write SHALL never be asserted together, and reg_write and mem_write SHALL never be asserted together.

Reset
REQ-037 While reset=1 at a clock edge, the FSM SHALL enter FETCH; this applies in every state, including mid-wait in MEM_RD or MEM_WR.
REQ-038 In the reset cycle all 1-bit outputs SHALL be 0 and all multi-bit outputs SHALL be 0.
REQ-039 Once reset is released, the first cycle SHALL be FETCH with the FETCH outputs.

Structure
REQ-040 The opcode constants, funct constants, state encodings and mux-select encodings SHALL be defined in a shared package, mips_pkg.
REQ-041 SHALL be a single module with no sub-modules; the next-state logic and output decode SHALL be separate combinational blocks.

Verification
REQ-042 With mem_ready tied to 1, lw (opcode 100011) SHALL take 5 cycles (FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB), with instr_done in cycle 5 and reg_write=1 with mem_to_reg=01 in cycle 5.
REQ-043 With sw, and mem_ready=0 for 3 cycles in MEM_WR, the FSM SHALL hold in MEM_WR for those 3 cycles with mem_write=1 throughout; the total SHALL be 7 cycles, with exactly 1 instr_done pulse.
REQ-044 R-type add (funct 100000) SHALL take 4 cycles with alu_op=10 in EXEC_R; jr (funct 001000) SHALL take 3 cycles with pc_source=11 and reg_write=0 throughout.
REQ-045 beq SHALL take 3 cycles with pc_write_cond=1 and alu_op=01 in cycle 3; jal SHALL take 3 cycles with reg_dst=10, mem_to_reg=10, pc_write=1 and pc_source=10 in cycle 3.
REQ-046 Opcode 111111 SHALL pulse illegal_op in DECODE and be back in FETCH on the next cycle, with no reg_write or mem_write asserted.
REQ-047 Asserting reset during MEM_RD with mem_ready=0 SHALL put the FSM in FETCH on the next cycle with all outputs 0 during the reset cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct
// codes, FSM state encodings and datapath mux selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_e;

  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_A      = 1'b1;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] DST_RT      = 2'b00;
  localparam logic [1:0] DST_RD      = 2'b01;
  localparam logic [1:0] DST_R31     = 2'b10;

  localparam logic [1:0] WB_ALUOUT   = 2'b00;
  localparam logic [1:0] WB_MDR      = 2'b01;
  localparam logic [1:0] WB_PC       = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle MIPS datapath with a shared,
// variable-latency memory.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state_dbg
);

  state_e     state_q, state_d;
  state_e     dec_tgt;
  logic [5:0] opc;
  logic [5:0] fn;

  assign opc = 6'(opcode);
  assign fn  = 6'(funct);

  always_comb begin
    dec_tgt = S_FETCH;
    unique case (opc)
      OP_RTYPE: dec_tgt = (fn == FN_JR) ? S_JR : S_EXEC_R;
      OP_LW,
      OP_SW:    dec_tgt = S_MEM_ADR;
      OP_BEQ:   dec_tgt = S_BRANCH;
      OP_ADDI:  dec_tgt = S_ADDI_EX;
      OP_J:     dec_tgt = S_JUMP;
      OP_JAL:   dec_tgt = S_JAL;
      default:  dec_tgt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = dec_tgt;
      S_MEM_ADR: state_d = (opc == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:  state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low, even while state_q still holds a wait state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    reg_dst       = DST_RT;
    mem_to_reg    = WB_ALUOUT;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    state_dbg     = 4'd0;
    if (!reset) begin
      state_dbg = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH;
          illegal_op = (dec_tgt == S_FETCH);
        end
        S_MEM_ADR, S_ADDI_EX: begin
          alu_src_a = SRCA_A;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
          instr_done = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_A;
          alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RD;
          instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = SRCA_A;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_R31;
          mem_to_reg = WB_PC;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_REG;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
